// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared definitions for the PLL reset sequencer.
//   - seq_state_t : FSM state type with fixed 2-bit encodings (visible on state_o)
//   - STAT_W      : width of the saturating statistics counters
//   - DEF_*       : default cycle parameters for a 50 MHz reference clock
//   - max_of4     : helper used to size the shared cycle counter
package pll_seq_pkg;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int unsigned STAT_W = 8;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 500000;
  localparam int unsigned DEF_POST_LOCK_CYCLES    = 256;

  function automatic int unsigned max_of4(input int unsigned a, input int unsigned b,
                                          input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if: signal bundle between the sequencer, the PLL and the core.
//   pll_locked   : PLL locked flag (asynchronous to refclk)
//   soft_rst_req : single-cycle request to re-sequence the PLL
//   pll_rst      : active-high PLL reset
//   core_rst     : active-high downstream reset
//   ready        : high only in RUN
//   state_o      : current FSM state encoding
//   retry_cnt    : saturating lock-timeout count
//   loss_cnt     : saturating lock-loss-in-RUN count
// Modports: master = sequencer side, slave = PLL/core/system side.
interface pll_reset_sequencer_if;
  import pll_seq_pkg::*;

  logic              pll_locked;
  logic              soft_rst_req;
  logic              pll_rst;
  logic              core_rst;
  logic              ready;
  logic [1:0]        state_o;
  logic [STAT_W-1:0] retry_cnt;
  logic [STAT_W-1:0] loss_cnt;

  modport master (
    input  pll_locked, soft_rst_req,
    output pll_rst, core_rst, ready, state_o, retry_cnt, loss_cnt
  );

  modport slave (
    output pll_locked, soft_rst_req,
    input  pll_rst, core_rst, ready, state_o, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for a single asynchronous bit.
//   clk     : destination clock
//   rst_n   : asynchronous active-low reset; both flops load RST_VAL
//   d       : asynchronous input
//   q       : synchronized output (2 clk latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: power-up and lock-supervision sequencer for the system PLL.
// Holds the PLL in reset, waits for a stable lock, applies a hold-off, then
// releases core_rst. Lock loss, lock timeout or soft_rst_req re-sequence the PLL.
//   refclk : free-running 50 MHz reference clock (sole clock)
//   rst_n  : asynchronous active-low reset
//   bus    : pll_reset_sequencer_if.master (locked/request inputs, reset/status outputs)
// Optional macro PLL_RESET_SEQ_STATS_EN: implements retry_cnt/loss_cnt; when
// undefined both read as zero and their flops are absent.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned POST_LOCK_CYCLES    = DEF_POST_LOCK_CYCLES
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  pll_reset_sequencer_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(max_of4(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                                 LOCK_TIMEOUT_CYCLES, POST_LOCK_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] POST_LAST    = CNT_W'(POST_LOCK_CYCLES - 1);

  logic             lk_s;
  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] stab_q, stab_d;
  logic             retry_inc, loss_inc;
  logic             pll_rst_q, core_rst_q, ready_q;

  sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.pll_locked),
    .q     (lk_s)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_PLL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    stab_d    = '0;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    if (bus.soft_rst_req && (state_q != RESET_PLL)) begin
      state_d = RESET_PLL;
    end else begin
      unique case (state_q)
        RESET_PLL: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          // Stable lock is tested before the timeout so lock wins a tie.
          if (lk_s && (stab_q == STABLE_LAST)) begin
            state_d = HOLD;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = RESET_PLL;
            retry_inc = 1'b1;
          end else if (lk_s) begin
            stab_d = stab_q + CNT_W'(1);
          end
        end
        HOLD: begin
          if (!lk_s)                  state_d = WAIT_LOCK;
          else if (cnt_q == POST_LAST) state_d = RUN;
        end
        RUN: begin
          if (!lk_s) begin
            state_d  = RESET_PLL;
            loss_inc = 1'b1;
          end
        end
        default: state_d = RESET_PLL;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_o.
  // cnt is parked in RUN, where no timer is needed, so it cannot wrap.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      stab_q     <= '0;
      pll_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      stab_q <= stab_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (state_q != RUN) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      pll_rst_q  <= (state_d == RESET_PLL);
      core_rst_q <= (state_d != RUN);
      ready_q    <= (state_d == RUN);
    end
  end

  assign bus.pll_rst  = pll_rst_q;
  assign bus.core_rst = core_rst_q;
  assign bus.ready    = ready_q;
  assign bus.state_o  = state_q;

`ifdef PLL_RESET_SEQ_STATS_EN
  logic [STAT_W-1:0] retry_q, loss_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      if (retry_inc && (retry_q != '1)) retry_q <= retry_q + STAT_W'(1);
      if (loss_inc && (loss_q != '1))   loss_q  <= loss_q + STAT_W'(1);
    end
  end

  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;
`else
  logic unused_stat_events;
  assign unused_stat_events = retry_inc ^ loss_inc;
  assign bus.retry_cnt = '0;
  assign bus.loss_cnt  = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed bench for pll_reset_sequencer with short
// cycle parameters (4/8/50/6). Expected latencies and counter values are
// hand-derived; counter expectations follow PLL_RESET_SEQ_STATS_EN.
module tb_pll_reset_sequencer;
  import pll_seq_pkg::*;

`ifdef PLL_RESET_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic refclk = 1'b0;
  logic rst_n;
  int   n_vec    = 0;
  int   n_miss   = 0;
  int   core_low = 0;

  pll_reset_sequencer_if bus ();

  always #10 refclk = ~refclk;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES      (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (50),
    .POST_LOCK_CYCLES    (6)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; samples are taken 1 ns after the rising edge.
  task automatic tick();
    @(posedge refclk);
    #1;
    if (bus.core_rst !== 1'b1) core_low++;
  endtask

  function automatic logic [2:0] outs_for(input logic [1:0] st);
    case (st)
      2'd0:    return 3'b110;   // {pll_rst, core_rst, ready}
      2'd3:    return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  task automatic wait_state(input logic [1:0] st, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (bus.state_o === st) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic expect_state(input string tag, input logic [1:0] st, input int budget,
                              input int n_exp);
    int n;
    wait_state(st, budget, n);
    check_val({tag, " latency"}, n, n_exp);
    check_val({tag, " outs"}, {bus.pll_rst, bus.core_rst, bus.ready}, outs_for(st));
  endtask

  initial begin
    int sat_cyc;
    int n;
    rst_n            = 1'b0;
    bus.pll_locked   = 1'b0;
    bus.soft_rst_req = 1'b0;
    repeat (3) tick();
    check_val("reset state", bus.state_o, RESET_PLL);
    check_val("reset outs", {bus.pll_rst, bus.core_rst, bus.ready}, 3'b110);
    check_val("reset retry", bus.retry_cnt, 0);
    check_val("reset loss", bus.loss_cnt, 0);

    // Power-up: lock rises 10 cycles after release.
    rst_n    = 1'b1;
    core_low = 0;
    expect_state("pu wait_lock", WAIT_LOCK, 20, 4);
    repeat (6) tick();
    bus.pll_locked = 1'b1;
    expect_state("pu hold", HOLD, 40, 10);
    check_val("pu core_rst held", core_low, 0);
    expect_state("pu run", RUN, 20, 6);

    // Soft request from RUN, then a glitchy lock.
    bus.soft_rst_req = 1'b1;
    bus.pll_locked   = 1'b0;
    expect_state("soft req", RESET_PLL, 3, 1);
    bus.soft_rst_req = 1'b0;
    check_val("soft req loss", bus.loss_cnt, 0);
    expect_state("glitch wait_lock", WAIT_LOCK, 10, 4);
    bus.pll_locked = 1'b1;
    repeat (5) tick();
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    expect_state("glitch hold", HOLD, 30, 10);
    expect_state("glitch run", RUN, 20, 6);

    // One-cycle lock drop in RUN: RESET_PLL 3 cycles after the drop.
    bus.pll_locked = 1'b0;
    tick();
    bus.pll_locked = 1'b1;
    check_val("loss still run", bus.state_o, RUN);
    expect_state("loss reset_pll", RESET_PLL, 10, 2);
    check_val("loss cnt", bus.loss_cnt, STATS ? 1 : 0);
    expect_state("relock wait_lock", WAIT_LOCK, 10, 4);
    expect_state("relock hold", HOLD, 20, 8);
    expect_state("relock run", RUN, 20, 6);

    // soft_rst_req coincides with lk_s falling: no loss counted.
    bus.pll_locked = 1'b0;
    tick();
    tick();
    check_val("prio pre", bus.state_o, RUN);
    bus.soft_rst_req = 1'b1;
    expect_state("prio reset_pll", RESET_PLL, 3, 1);
    bus.soft_rst_req = 1'b0;
    check_val("prio loss", bus.loss_cnt, STATS ? 1 : 0);

    // Request inside RESET_PLL does not extend it.
    tick();
    bus.soft_rst_req = 1'b1;
    tick();
    bus.soft_rst_req = 1'b0;
    expect_state("soft ignored", WAIT_LOCK, 10, 2);

    // Lock timeouts.
    core_low = 0;
    for (int i = 1; i <= 3; i++) begin
      expect_state($sformatf("timeout%0d reset_pll", i), RESET_PLL, 60, 50);
      check_val($sformatf("timeout%0d retry", i), bus.retry_cnt, STATS ? i : 0);
      expect_state($sformatf("timeout%0d wait_lock", i), WAIT_LOCK, 10, 4);
    end
    check_val("timeout core_rst held", core_low, 0);

    sat_cyc = 0;
    for (int i = 0; i < 297; i++) begin
      wait_state(RESET_PLL, 60, n);
      sat_cyc += n;
      wait_state(WAIT_LOCK, 10, n);
      sat_cyc += n;
    end
    check_val("sat cycles", sat_cyc, 297 * 54);
    check_val("sat retry", bus.retry_cnt, STATS ? 255 : 0);
    check_val("sat loss", bus.loss_cnt, STATS ? 1 : 0);

    // Asynchronous reset mid-sequence.
    tick();
    #3;
    rst_n = 1'b0;
    #2;
    check_val("async state", bus.state_o, RESET_PLL);
    check_val("async outs", {bus.pll_rst, bus.core_rst, bus.ready}, 3'b110);
    check_val("async retry", bus.retry_cnt, 0);
    check_val("async loss", bus.loss_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    expect_state("restart wait_lock", WAIT_LOCK, 10, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
